// File: rtl/mem_tester.sv
// Self-checking memory-port traffic generator: writes a seeded pattern over a strided
// window, reads it back and compares, over one or more passes.
module mem_tester #(
    parameter int unsigned            ADDR_WIDTH = 64,
    parameter int unsigned            WORD_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0]  BASE       = '0,
    parameter logic [ADDR_WIDTH-1:0]  STRIDE     = ADDR_WIDTH'(1),
    parameter int unsigned            COUNT      = 256,
    parameter int unsigned            PASSES     = 1,
    parameter int unsigned            MODE       = 0,
    parameter logic [WORD_WIDTH-1:0]  SEED       = WORD_WIDTH'(64'h0123456789abcdef),
    parameter int unsigned            TIMEOUT    = 1024,
    parameter int unsigned            ERR_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [ERR_WIDTH-1:0]  err_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [WORD_WIDTH-1:0] fail_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_din,
    input  logic [WORD_WIDTH-1:0] mem_dout,
    output logic                  mem_re,
    output logic                  mem_we,
    input  logic                  mem_ready
);

    localparam int unsigned IDX_W      = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam int unsigned PASS_W     = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam int unsigned TMR_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit          INTERLEAVE = (MODE == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE_W,
        S_WAIT_W,
        S_ISSUE_R,
        S_WAIT_R,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [PASS_W-1:0]       pass_idx_q, pass_idx_d;
    logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic                    stale_q, stale_d;

    logic                    busy_d, done_d, pass_d, timeout_d;
    logic [ERR_WIDTH-1:0]    err_d;
    logic [ADDR_WIDTH-1:0]   fail_addr_d, addr_d;
    logic [WORD_WIDTH-1:0]   fail_data_d, din_d;
    logic                    re_d, we_d;

    logic                    in_wait;
    logic                    wait_idle;
    logic                    complete;
    logic                    expire;
    logic                    last_idx;
    logic                    more_passes;
    logic                    mismatch;
    logic [WORD_WIDTH-1:0]   exp_data;

    // Request bookkeeping shared by next-state and output logic
    assign in_wait     = (state_q == S_WAIT_W) || (state_q == S_WAIT_R);
    assign wait_idle   = in_wait && !stale_q && !mem_ready;
    assign complete    = in_wait && !stale_q && mem_ready;
    assign expire      = wait_idle && (TIMEOUT != 0) && (32'(timer_q) == TIMEOUT - 32'd1);
    assign last_idx    = (32'(idx_q) == COUNT - 32'd1);
    assign more_passes = ((32'(pass_idx_q) + 32'd1) < PASSES);
    assign exp_data    = (WORD_WIDTH'(idx_q) ^ SEED) ^ {WORD_WIDTH{pass_idx_q[0]}};
    assign mismatch    = (mem_dout != exp_data);

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            pass_idx_q <= '0;
            cur_addr_q <= '0;
            timer_q    <= '0;
            stale_q    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            err_count  <= '0;
            fail_addr  <= '0;
            fail_data  <= '0;
            mem_addr   <= '0;
            mem_din    <= '0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pass_idx_q <= pass_idx_d;
            cur_addr_q <= cur_addr_d;
            timer_q    <= timer_d;
            stale_q    <= stale_d;
            busy       <= busy_d;
            done       <= done_d;
            pass       <= pass_d;
            timeout    <= timeout_d;
            err_count  <= err_d;
            fail_addr  <= fail_addr_d;
            fail_data  <= fail_data_d;
            mem_addr   <= addr_d;
            mem_din    <= din_d;
            mem_re     <= re_d;
            mem_we     <= we_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) state_d = S_ISSUE_W;
            end
            S_ISSUE_W: begin
                if (mem_ready) state_d = S_WAIT_W;
            end
            S_ISSUE_R: begin
                if (mem_ready) state_d = S_WAIT_R;
            end
            S_WAIT_W: begin
                if (expire) begin
                    state_d = S_DONE;
                end else if (complete) begin
                    state_d = (INTERLEAVE || last_idx) ? S_ISSUE_R : S_ISSUE_W;
                end
            end
            S_WAIT_R: begin
                if (expire) begin
                    state_d = S_DONE;
                end else if (complete) begin
                    if (last_idx) begin
                        state_d = more_passes ? S_ISSUE_W : S_DONE;
                    end else begin
                        state_d = INTERLEAVE ? S_ISSUE_W : S_ISSUE_R;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        idx_d       = idx_q;
        pass_idx_d  = pass_idx_q;
        cur_addr_d  = cur_addr_q;
        timer_d     = timer_q;
        stale_d     = 1'b0;
        re_d        = 1'b0;
        we_d        = 1'b0;
        addr_d      = mem_addr;
        din_d       = mem_din;
        err_d       = err_count;
        fail_addr_d = fail_addr;
        fail_data_d = fail_data;
        timeout_d   = timeout;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    idx_d       = '0;
                    pass_idx_d  = '0;
                    cur_addr_d  = BASE;
                    timer_d     = '0;
                    err_d       = '0;
                    fail_addr_d = '0;
                    fail_data_d = '0;
                    timeout_d   = 1'b0;
                end
            end
            S_ISSUE_W, S_ISSUE_R: begin
                if (mem_ready) begin
                    we_d    = (state_q == S_ISSUE_W);
                    re_d    = (state_q == S_ISSUE_R);
                    addr_d  = cur_addr_q;
                    if (state_q == S_ISSUE_W) din_d = exp_data;
                    stale_d = 1'b1;
                    timer_d = '0;
                end
            end
            S_WAIT_W, S_WAIT_R: begin
                if (expire) begin
                    timeout_d = 1'b1;
                end else if (wait_idle && (TIMEOUT != 0)) begin
                    timer_d = timer_q + TMR_W'(1);
                end

                if (complete) begin
                    if ((state_q == S_WAIT_R) && mismatch) begin
                        err_d = (&err_count) ? err_count : err_count + ERR_WIDTH'(1);
                        if (err_count == '0) begin
                            fail_addr_d = mem_addr;
                            fail_data_d = mem_dout;
                        end
                    end
                    // Interleaved writes reuse their index for the following read
                    if ((state_q == S_WAIT_R) || !INTERLEAVE) begin
                        if (last_idx) begin
                            idx_d      = '0;
                            cur_addr_d = BASE;
                            if ((state_q == S_WAIT_R) && more_passes) begin
                                pass_idx_d = pass_idx_q + PASS_W'(1);
                            end
                        end else begin
                            idx_d      = idx_q + IDX_W'(1);
                            cur_addr_d = cur_addr_q + STRIDE;
                        end
                    end
                end
            end
            default: ;
        endcase

        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
        pass_d = done_d && (err_d == '0) && !timeout_d;
    end

endmodule

// File: tb/tb_mem_tester.sv
// Scoreboard bench for mem_tester: three configurations, each in front of a small
// behavioural memory with random ready latency and fault/hang injection.
module tb_mem_tester;

    localparam logic [63:0] SEED = 64'h0123456789abcdef;

    typedef struct {
        bit          we;
        logic [63:0] addr;
        logic [63:0] data;
    } req_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A: COUNT=4, BASE=1, STRIDE=256, MODE=0
    logic        busy_a, done_a, pass_a, to_a, re_a, we_a, rdy_a;
    logic [15:0] err_a;
    logic [63:0] faddr_a, fdata_a, addr_a, din_a, dout_a;
    // Instance B: interleaved, two passes
    logic        busy_b, done_b, pass_b, to_b, re_b, we_b, rdy_b;
    logic [15:0] err_b;
    logic [63:0] faddr_b, fdata_b, addr_b, din_b, dout_b;
    // Instance C: 2-bit saturating error counter
    logic        busy_c, done_c, pass_c, to_c, re_c, we_c, rdy_c;
    logic [1:0]  err_c;
    logic [63:0] faddr_c, fdata_c, addr_c, din_c, dout_c;

    mem_tester #(.BASE(64'd1), .STRIDE(64'd256), .COUNT(4), .PASSES(1), .MODE(0),
                 .SEED(SEED), .TIMEOUT(50), .ERR_WIDTH(16)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .timeout(to_a), .err_count(err_a), .fail_addr(faddr_a), .fail_data(fdata_a),
        .mem_addr(addr_a), .mem_din(din_a), .mem_dout(dout_a), .mem_re(re_a),
        .mem_we(we_a), .mem_ready(rdy_a));

    mem_tester #(.BASE(64'd1), .STRIDE(64'd256), .COUNT(2), .PASSES(2), .MODE(1),
                 .SEED(SEED), .TIMEOUT(50), .ERR_WIDTH(16)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .timeout(to_b), .err_count(err_b), .fail_addr(faddr_b), .fail_data(fdata_b),
        .mem_addr(addr_b), .mem_din(din_b), .mem_dout(dout_b), .mem_re(re_b),
        .mem_we(we_b), .mem_ready(rdy_b));

    mem_tester #(.BASE(64'd16), .STRIDE(64'd1), .COUNT(8), .PASSES(1), .MODE(0),
                 .SEED(SEED), .TIMEOUT(50), .ERR_WIDTH(2)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .busy(busy_c), .done(done_c), .pass(pass_c),
        .timeout(to_c), .err_count(err_c), .fail_addr(faddr_c), .fail_data(fdata_c),
        .mem_addr(addr_c), .mem_din(din_c), .mem_dout(dout_c), .mem_re(re_c),
        .mem_we(we_c), .mem_ready(rdy_c));

    // Behavioural memories: ready drops for a random number of cycles after each strobe
    logic [63:0] mem_a [0:1023];
    logic [63:0] mem_b [0:1023];
    logic [63:0] mem_c [0:1023];
    int  cnt_a = 0, cnt_b = 0, cnt_c = 0;
    bit  hang_a = 1'b0, fault_a = 1'b0, fast_a = 1'b0;

    assign rdy_a = (cnt_a == 0);
    assign rdy_b = (cnt_b == 0);
    assign rdy_c = (cnt_c == 0);

    always @(posedge clk) begin
        if (rst) begin
            cnt_a <= 0;
        end else if (we_a || re_a) begin
            if (we_a) mem_a[addr_a[9:0]] <= din_a;
            if (re_a) dout_a <= mem_a[addr_a[9:0]] ^ ((fault_a && addr_a == 64'd257) ? 64'd1 : 64'd0);
            cnt_a <= hang_a ? 1000000 : (fast_a ? 0 : int'($urandom_range(0, 3)));
        end else if (cnt_a != 0) begin
            cnt_a <= cnt_a - 1;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            cnt_b <= 0;
        end else if (we_b || re_b) begin
            if (we_b) mem_b[addr_b[9:0]] <= din_b;
            if (re_b) dout_b <= mem_b[addr_b[9:0]];
            cnt_b <= int'($urandom_range(0, 3));
        end else if (cnt_b != 0) begin
            cnt_b <= cnt_b - 1;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            cnt_c <= 0;
        end else if (we_c || re_c) begin
            if (we_c) mem_c[addr_c[9:0]] <= din_c;
            if (re_c) dout_c <= mem_c[addr_c[9:0]] ^ 64'd1;
            cnt_c <= int'($urandom_range(0, 2));
        end else if (cnt_c != 0) begin
            cnt_c <= cnt_c - 1;
        end
    end

    // Scoreboards: each observed strobe is popped against the expected request order
    req_t q_a[$];
    req_t q_b[$];
    req_t ea, eb;
    int   strobes_a = 0, strobes_b = 0, strobes_c = 0;
    int   last_a = -1, min_gap_a = 1000;

    always @(negedge clk) begin
        if (!rst && (re_a || we_a)) begin
            strobes_a++;
            n_checks++;
            if (re_a && we_a) begin
                n_fail++;
                $display("FAIL a_both_strobes re=%0b we=%0b required only one", re_a, we_a);
            end
            n_checks++;
            if (q_a.size() == 0) begin
                n_fail++;
                $display("FAIL a_unexpected_strobe we=%0b addr=%0d required no strobe", we_a, addr_a);
            end else begin
                ea = q_a.pop_front();
                if (we_a !== ea.we || addr_a !== ea.addr || (ea.we && din_a !== ea.data)) begin
                    n_fail++;
                    $display("FAIL a_request we=%0b addr=%0d din=%h required we=%0b addr=%0d din=%h",
                             we_a, addr_a, din_a, ea.we, ea.addr, ea.data);
                end
            end
            if (last_a >= 0) begin
                n_checks++;
                if (cyc - last_a < 3) begin
                    n_fail++;
                    $display("FAIL a_strobe_gap gap=%0d required >=3", cyc - last_a);
                end
                if (cyc - last_a < min_gap_a) min_gap_a = cyc - last_a;
            end
            last_a = cyc;
        end
    end

    always @(negedge clk) begin
        if (!rst && (re_b || we_b)) begin
            strobes_b++;
            n_checks++;
            if (q_b.size() == 0) begin
                n_fail++;
                $display("FAIL b_unexpected_strobe we=%0b addr=%0d required no strobe", we_b, addr_b);
            end else begin
                eb = q_b.pop_front();
                if (re_b === we_b || we_b !== eb.we || addr_b !== eb.addr ||
                    (eb.we && din_b !== eb.data)) begin
                    n_fail++;
                    $display("FAIL b_request re=%0b we=%0b addr=%0d din=%h required we=%0b addr=%0d din=%h",
                             re_b, we_b, addr_b, din_b, eb.we, eb.addr, eb.data);
                end
            end
        end
        if (!rst && (re_c || we_c)) strobes_c++;
    end

    function automatic void push_a(bit we, logic [63:0] addr, logic [63:0] data);
        req_t r;
        r.we = we; r.addr = addr; r.data = data;
        q_a.push_back(r);
    endfunction

    function automatic void push_b(bit we, logic [63:0] addr, logic [63:0] data);
        req_t r;
        r.we = we; r.addr = addr; r.data = data;
        q_b.push_back(r);
    endfunction

    function automatic void push_run_a();
        for (int i = 0; i < 4; i++) push_a(1'b1, 64'd1 + 64'(i) * 64'd256, SEED ^ 64'(i));
        for (int i = 0; i < 4; i++) push_a(1'b0, 64'd1 + 64'(i) * 64'd256, 64'd0);
    endfunction

    task automatic pulse_start(input int sel);
        @(negedge clk);
        if (sel == 0) start_a = 1'b1; else if (sel == 1) start_b = 1'b1; else start_c = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    endtask

    task automatic wait_done(input int sel, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if ((sel == 0 && done_a) || (sel == 1 && done_b) || (sel == 2 && done_c)) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy_a, done_a, pass_a, to_a, re_a, we_a} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags busy/done/pass/timeout/re/we=%b required 000000",
                     {busy_a, done_a, pass_a, to_a, re_a, we_a});
        end
        n_checks++;
        if (err_a !== 16'd0 || faddr_a !== 64'd0 || fdata_a !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_status err=%0d fail_addr=%0d fail_data=%h required 0", err_a, faddr_a, fdata_a);
        end
        n_checks++;
        if (addr_a !== 64'd0 || din_a !== 64'd0 || busy_b !== 1'b0 || err_c !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_bus addr=%0d din=%h busy_b=%0b err_c=%0d required 0", addr_a, din_a, busy_b, err_c);
        end
    endtask

    task automatic test_basic();
        bit ok;
        push_run_a();
        pulse_start(0);
        repeat (4) @(negedge clk);
        pulse_start(0);   // ignored while busy
        wait_done(0, 400, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL basic_done done=0 required 1 within 400 cycles"); end
        n_checks++;
        if (q_a.size() != 0) begin n_fail++; $display("FAIL basic_requests left=%0d required 0", q_a.size()); end
        n_checks++;
        if (pass_a !== 1'b1 || err_a !== 16'd0 || faddr_a !== 64'd0 || to_a !== 1'b0 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result pass=%0b err=%0d fail_addr=%0d timeout=%0b busy=%0b required 1,0,0,0,0",
                     pass_a, err_a, faddr_a, to_a, busy_a);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (done_a !== 1'b1 || pass_a !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_hold done=%0b pass=%0b required 1,1", done_a, pass_a);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        fast_a = 1'b1;
        min_gap_a = 1000;
        last_a = -1;
        push_run_a();
        pulse_start(0);
        wait_done(0, 400, ok);
        n_checks++;
        if (!ok || min_gap_a != 3 || pass_a !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_gap done=%0b min_gap=%0d pass=%0b required 1,3,1", ok, min_gap_a, pass_a);
        end
        fast_a = 1'b0;
    endtask

    task automatic test_fault();
        bit ok;
        fault_a = 1'b1;
        push_run_a();
        pulse_start(0);
        wait_done(0, 400, ok);
        n_checks++;
        if (!ok || q_a.size() != 0) begin
            n_fail++;
            $display("FAIL fault_done done=%0b left=%0d required 1,0", ok, q_a.size());
        end
        n_checks++;
        if (err_a !== 16'd1 || faddr_a !== 64'd257) begin
            n_fail++;
            $display("FAIL fault_count err=%0d fail_addr=%0d required 1,257", err_a, faddr_a);
        end
        n_checks++;
        if (fdata_a !== ((SEED ^ 64'd1) ^ 64'd1) || pass_a !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_data fail_data=%h pass=%0b required %h,0", fdata_a, pass_a, (SEED ^ 64'd1) ^ 64'd1);
        end
        fault_a = 1'b0;
    endtask

    task automatic test_timeout();
        bit ok;
        int s0, lat;
        hang_a = 1'b1;
        push_a(1'b1, 64'd1, SEED);
        pulse_start(0);
        wait_done(0, 200, ok);
        lat = cyc - last_a;
        n_checks++;
        if (!ok || to_a !== 1'b1 || pass_a !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_flag done=%0b timeout=%0b pass=%0b required 1,1,0", ok, to_a, pass_a);
        end
        n_checks++;
        if (lat < 50 || lat > 52) begin
            n_fail++;
            $display("FAIL timeout_latency cycles=%0d required 50..52", lat);
        end
        s0 = strobes_a;
        repeat (10) @(negedge clk);
        n_checks++;
        if (strobes_a != s0 || q_a.size() != 0 || we_a !== 1'b0 || re_a !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_quiet strobes=%0d left=%0d required %0d,0", strobes_a, q_a.size(), s0);
        end
        hang_a = 1'b0;
    endtask

    task automatic test_interleaved_passes();
        bit ok;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 2; i++) begin
                push_b(1'b1, 64'd1 + 64'(i) * 64'd256, (p == 1) ? ~(SEED ^ 64'(i)) : (SEED ^ 64'(i)));
                push_b(1'b0, 64'd1 + 64'(i) * 64'd256, 64'd0);
            end
        end
        pulse_start(1);
        wait_done(1, 400, ok);
        n_checks++;
        if (!ok || q_b.size() != 0 || strobes_b != 8) begin
            n_fail++;
            $display("FAIL mode1_order done=%0b left=%0d strobes=%0d required 1,0,8", ok, q_b.size(), strobes_b);
        end
        n_checks++;
        if (pass_b !== 1'b1 || err_b !== 16'd0) begin
            n_fail++;
            $display("FAIL mode1_result pass=%0b err=%0d required 1,0", pass_b, err_b);
        end
    endtask

    task automatic test_saturate();
        bit ok;
        pulse_start(2);
        wait_done(2, 600, ok);
        n_checks++;
        if (!ok || err_c !== 2'd3 || pass_c !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_count done=%0b err=%0d pass=%0b required 1,3,0", ok, err_c, pass_c);
        end
        n_checks++;
        if (faddr_c !== 64'd16 || fdata_c !== (SEED ^ 64'd1) || strobes_c != 16) begin
            n_fail++;
            $display("FAIL sat_first fail_addr=%0d fail_data=%h strobes=%0d required 16,%h,16",
                     faddr_c, fdata_c, strobes_c, SEED ^ 64'd1);
        end
    endtask

    task automatic test_reset_midrun();
        bit ok;
        int s0, n;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q_a.delete();
        last_a = -1;
        push_run_a();
        s0 = strobes_a;
        pulse_start(0);
        n = 0;
        while (strobes_a < s0 + 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (strobes_a < s0 + 3) begin
            n_fail++;
            $display("FAIL midrun_strobes strobes=%0d required %0d", strobes_a - s0, 3);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy_a, done_a, pass_a, to_a, re_a, we_a} !== 6'b0 || err_a !== 16'd0 ||
            addr_a !== 64'd0 || din_a !== 64'd0 || faddr_a !== 64'd0 || fdata_a !== 64'd0) begin
            n_fail++;
            $display("FAIL midrun_reset flags=%b err=%0d addr=%0d din=%h required all 0",
                     {busy_a, done_a, pass_a, to_a, re_a, we_a}, err_a, addr_a, din_a);
        end
        rst = 1'b0;
        q_a.delete();
        last_a = -1;
        push_run_a();
        pulse_start(0);
        wait_done(0, 400, ok);
        n_checks++;
        if (!ok || pass_a !== 1'b1 || q_a.size() != 0) begin
            n_fail++;
            $display("FAIL midrun_restart done=%0b pass=%0b left=%0d required 1,1,0", ok, pass_a, q_a.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_fault();
        test_timeout();
        test_interleaved_passes();
        test_saturate();
        test_reset_midrun();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
